// File: rtl/div_repsub.sv
// -----------------------------------------------------------------------------
// div_repsub
//   Unsigned integer divider built on repeated subtraction. It is the inverse
//   companion of the repeated-addition multiplier and uses the same host
//   handshake: after start, the block asks for the dividend with lda and then
//   for the divisor with ldb, both on the shared datain bus. It then subtracts
//   the divisor from the running remainder once per cycle until the remainder
//   is smaller than the divisor.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        level; sampled in IDLE to begin an operation
//   datain       shared operand bus (dividend while lda, divisor while ldb)
//   lda          high in the cycle the dividend is captured
//   ldb          high in the cycle the divisor is captured
//   busy         high while loading operands or dividing
//   done         one-cycle pulse; results are valid
//   div_by_zero  set together with done when the divisor was zero
//   quotient     registered quotient
//   remainder    registered remainder
// -----------------------------------------------------------------------------
module div_repsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] datain,
    output logic             lda,
    output logic             ldb,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_CALC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_b;
    logic             r_dbz;

    logic             w_b_zero;
    logic             w_can_sub;

    assign w_b_zero  = (r_b == '0);
    // The running remainder doubles as the dividend register, so this compare
    // is what keeps the subtraction below from ever wrapping.
    assign w_can_sub = (r_rem >= r_b);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and Moore output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        lda         = 1'b0;
        ldb         = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LDA;
                end
            end
            S_LDA: begin
                lda         = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_LDB;
            end
            S_LDB: begin
                ldb         = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                // A zero divisor finishes at once; otherwise keep subtracting
                // while the remainder still covers the divisor.
                if (w_b_zero || !w_can_sub) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand capture and one subtraction per CALC cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_LDA: begin
                    r_rem  <= datain;
                    r_quot <= '0;
                    r_dbz  <= 1'b0;
                end
                S_LDB: begin
                    r_b <= datain;
                end
                S_CALC: begin
                    if (w_b_zero) begin
                        // Remainder keeps the dividend; quotient saturates.
                        r_quot <= '1;
                        r_dbz  <= 1'b1;
                    end else if (w_can_sub) begin
                        r_rem  <= r_rem - r_b;
                        r_quot <= r_quot + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_repsub.sv
module tb_div_repsub;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] datain;
    logic             lda;
    logic             ldb;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    div_repsub #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .datain      (datain),
        .lda         (lda),
        .ldb         (ldb),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc is the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int               e0;   // rising edge that samples start
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             z;
    } op_t;

    op_t              mq[$];
    logic [WIDTH-1:0] last_q = '0;
    logic [WIDTH-1:0] last_r = '0;
    logic             last_z = 1'b0;
    logic [WIDTH-1:0] cur_a  = '0;
    logic [WIDTH-1:0] cur_b  = '0;

    function automatic op_t model(input int e0, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        op_t o;
        o.e0 = e0;
        if (b == '0) begin
            o.q = '1;
            o.r = a;
            o.z = 1'b1;
        end else begin
            o.q = a / b;
            o.r = a % b;
            o.z = 1'b0;
        end
        return o;
    endfunction

    // Host side of the shared operand bus.
    always_comb begin
        datain = 16'hA5A5;
        if (lda)      datain = cur_a;
        else if (ldb) datain = cur_b;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        op_t  op;
        int   d;
        logic have;
        logic e_lda, e_ldb, e_busy, e_done;
        if (rst_n) begin
            have   = 1'b0;
            d      = 0;
            e_lda  = 1'b0;
            e_ldb  = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            op     = '{e0: 0, q: '0, r: '0, z: 1'b0};
            if (mq.size() > 0) begin
                op     = mq[0];
                have   = 1'b1;
                d      = op.e0 + (op.z ? 0 : int'(op.q)) + 3;
                e_lda  = (cyc == op.e0);
                e_ldb  = (cyc == op.e0 + 1);
                e_busy = (cyc >= op.e0) && (cyc < d);
                e_done = (cyc == d);
            end
            check("lda",  32'(lda),  32'(e_lda));
            check("ldb",  32'(ldb),  32'(e_ldb));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            if (have && cyc == d) begin
                check("quotient",    32'(quotient),    32'(op.q));
                check("remainder",   32'(remainder),   32'(op.r));
                check("div_by_zero", 32'(div_by_zero), 32'(op.z));
                last_q = op.q;
                last_r = op.r;
                last_z = op.z;
                void'(mq.pop_front());
            end else if (!have || cyc <= op.e0) begin
                check("hold_quotient",    32'(quotient),    32'(last_q));
                check("hold_remainder",   32'(remainder),   32'(last_r));
                check("hold_div_by_zero", 32'(div_by_zero), 32'(last_z));
            end
        end
    end

    // ---------------- driver helpers (called just after a falling edge) ----
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int e0);
        cur_a = a;
        cur_b = b;
        mq.push_back(model(e0, a, b));
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int e0);
        start = 1'b1;
        e0    = cyc + 1;
        push_op(a, b, e0);
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int n = 0; n < 1000; n++) begin
            step();
            if (done) begin
                d = cyc;
                break;
            end
        end
        check("done_within_budget", 32'(d >= 0), 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int e0, output int d);
        launch(a, b, e0);
        step();
        start = 1'b0;
        wait_done(d);
        step();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int e0;
        int d;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) step();
        check("rst_quotient",    32'(quotient),    32'd0);
        check("rst_remainder",   32'(remainder),   32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        rst_n = 1'b1;
        step();

        run_op(16'd24, 16'd4, e0, d);
        check("24/4 q",   32'(quotient),  32'd6);
        check("24/4 r",   32'(remainder), 32'd0);
        check("24/4 lat", 32'(d - e0),    32'd9);

        run_op(16'd25, 16'd7, e0, d);
        check("25/7 q",   32'(quotient),  32'd3);
        check("25/7 r",   32'(remainder), 32'd4);
        check("25/7 lat", 32'(d - e0),    32'd6);

        run_op(16'd3, 16'd10, e0, d);
        check("3/10 q",   32'(quotient),  32'd0);
        check("3/10 r",   32'(remainder), 32'd3);
        check("3/10 lat", 32'(d - e0),    32'd3);

        run_op(16'd0, 16'd5, e0, d);
        check("0/5 q", 32'(quotient),  32'd0);
        check("0/5 r", 32'(remainder), 32'd0);

        run_op(16'd100, 16'd0, e0, d);
        check("100/0 z",   32'(div_by_zero), 32'd1);
        check("100/0 q",   32'(quotient),    32'h0000FFFF);
        check("100/0 r",   32'(remainder),   32'd100);
        check("100/0 lat", 32'(d - e0),      32'd3);

        run_op(16'd9, 16'd3, e0, d);
        check("9/3 z", 32'(div_by_zero), 32'd0);
        check("9/3 q", 32'(quotient),    32'd3);
        check("9/3 r", 32'(remainder),   32'd0);

        run_op(16'd7, 16'd7, e0, d);
        check("7/7 q", 32'(quotient),  32'd1);
        check("7/7 r", 32'(remainder), 32'd0);

        // Asynchronous reset in the middle of CALC.
        launch(16'd24, 16'd4, e0);
        step();
        start = 1'b0;
        while (cyc < e0 + 4) step();
        #2;
        rst_n = 1'b0;
        mq.delete();
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        #1;
        check("arst_quotient",    32'(quotient),    32'd0);
        check("arst_remainder",   32'(remainder),   32'd0);
        check("arst_div_by_zero", 32'(div_by_zero), 32'd0);
        check("arst_lda",         32'(lda),         32'd0);
        check("arst_ldb",         32'(ldb),         32'd0);
        check("arst_busy",        32'(busy),        32'd0);
        check("arst_done",        32'(done),        32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op(16'd15, 16'd5, e0, d);
        check("15/5 q", 32'(quotient),  32'd3);
        check("15/5 r", 32'(remainder), 32'd0);

        // start held high: back-to-back operations.
        launch(16'd50, 16'd7, e0);
        wait_done(d);
        check("held 50/7 q", 32'(quotient), 32'd7);
        push_op(16'd9, 16'd9, d + 2);
        wait_done(d);
        push_op(16'd0, 16'd5, d + 2);
        wait_done(d);
        start = 1'b0;
        repeat (3) step();

        // start pulse during CALC must be ignored.
        launch(16'd200, 16'd3, e0);
        step();
        start = 1'b0;
        while (cyc < e0 + 10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(d);
        check("200/3 q",   32'(quotient),  32'd66);
        check("200/3 r",   32'(remainder), 32'd2);
        check("200/3 lat", 32'(d - e0),    32'd69);
        repeat (3) step();

        check("model_drained", 32'(mq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_repsub.md
Name: div_repsub

Overview:
- Unsigned integer divider using repeated subtraction; the inverse companion of the team's repeated-addition multiplier.
- FSM and datapath live in one module.
- Operands arrive over a shared `datain` bus. The block requests them itself with `lda`/`ldb` load strobes, so the same bench/host sequencing used for the multiplier drives it unchanged.
- Produces quotient, remainder, a one-cycle `done` pulse and a divide-by-zero flag.

Parameters:
- WIDTH, 16, bit width of `datain`, dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; sampled in IDLE to begin an operation
- datain  input  WIDTH  shared operand bus; dividend while lda=1, divisor while ldb=1
- lda  output  1  high for exactly the cycle in which the dividend is captured
- ldb  output  1  high for exactly the cycle in which the divisor is captured
- busy  output  1  high in LDA, LDB, CALC
- done  output  1  one-cycle pulse; results valid
- div_by_zero  output  1  set with done when divisor=0; held with results
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - lda, ldb, busy, done, div_by_zero = 0.
  - quotient, remainder and internal divisor register B = 0.
  - Takes effect immediately, including mid-operation. Partial results are discarded.
- States: IDLE, LDA, LDB, CALC, DONE. lda/ldb/busy/done are decoded from state (Moore).
- IDLE: start=1 at an edge -> LDA; else stay. Outputs hold their last results.
- LDA:
  - lda=1.
  - At the edge: remainder <= datain, quotient <= 0, div_by_zero <= 0; -> LDB.
- LDB:
  - ldb=1.
  - At the edge: B <= datain; -> CALC.
- CALC, evaluated every edge using current register values:
  - B==0: quotient <= all-ones, remainder unchanged (= dividend), div_by_zero <= 1; -> DONE.
  - else remainder >= B: remainder <= remainder - B, quotient <= quotient + 1; stay.
  - else: -> DONE.
- DONE:
  - done=1 for one cycle; -> IDLE unconditionally.
  - start is ignored in DONE.
- Start handling:
  - start is ignored in LDA/LDB/CALC.
  - start held high re-triggers a new operation on the first edge back in IDLE.
- Latency, counting from the edge that samples start in IDLE as edge 0:
  - done is high in the cycle following edge Q+3, where Q is the final quotient.
  - Divide-by-zero: done is high following edge 3.
  - Total cycles from start to done pulse = Q+4.
- Arithmetic: unsigned, WIDTH-bit.
  - Subtraction never underflows; it is guarded by the >= compare.
  - The quotient cannot overflow: worst case A=2^WIDTH-1, B=1 gives Q=2^WIDTH-1, after 2^WIDTH-1 subtractions.
- Boundaries:
  - A<B: zero subtractions, Q=0, R=A.
  - A=0, B≠0: Q=0, R=0.
  - A=B: Q=1, R=0.
- Results:
  - quotient/remainder/div_by_zero are stable from the done cycle until the next LDA edge.
  - They may change during CALC; the host must not sample them before done.

Test Plan:
- start=1 in IDLE, datain=24 while lda=1, datain=4 while ldb=1 -> quotient=6, remainder=0, div_by_zero=0, done pulse high for 1 cycle after edge 9.
- A=25, B=7 -> quotient=3, remainder=4, done after edge 6. lda and ldb each observed high exactly one cycle, in consecutive cycles.
- A=3, B=10 -> quotient=0, remainder=3, done after edge 3. Separately A=0, B=5 -> quotient=0, remainder=0.
- A=100, B=0 -> div_by_zero=1, quotient=16'hFFFF, remainder=100, done after edge 3. Then a next op with A=9, B=3 clears the flag: quotient=3, remainder=0.
- Run A=24, B=4; assert rst_n=0 asynchronously mid-CALC (between clock edges) -> all outputs 0 and state IDLE immediately. After release, a new A=15, B=5 run gives quotient=3, remainder=0.
- Hold start=1 continuously -> back-to-back operations, each preceded by an lda/ldb pair. start pulses during CALC are ignored, with no change to the result or timing.
